// File: rtl/sub86_ifetch.sv
// Instruction prefetch for the sub86 core: streams 32-bit words from memory
// into a small FIFO and serves 16-bit parcels, stalling the core on a miss.
module sub86_ifetch #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] IA,
  output logic [15:0] ID,
  output logic        CE,
  output logic [31:0] MA,
  output logic        MREQ,
  input  logic        MRDY,
  input  logic [31:0] MD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {FILL, DISCARD} state_t;

  state_t        state, state_nx;
  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, sel_ptr;
  logic [CW-1:0] count;
  logic [29:0]   base, fetch, hold;

  logic [29:0]   ia_w, off;
  logic          hit0, hit1, hit, pending, redirect;
  logic          mreq_int, push, pop;
  logic [31:0]   ma_int, hit_word;
  logic [15:0]   parcel;
  logic          unused_ia0;

  assign unused_ia0 = IA[0];

  // Lookup: the current word or the one after it may be served.
  assign ia_w     = IA[31:2];
  assign off      = ia_w - base;
  assign hit0     = (count != '0) && (off == 30'd0);
  assign hit1     = (count >= CW'(2)) && (off == 30'd1);
  assign hit      = hit0 | hit1;
  assign pending  = (ia_w == fetch) && (off <= 30'(count));
  assign redirect = !hit && !pending;
  assign pop      = hit1;

  assign sel_ptr  = rd_ptr + PW'(hit1);
  assign hit_word = fifo_mem[sel_ptr];
  assign parcel   = IA[1] ? {hit_word[23:16], hit_word[31:24]}
                          : {hit_word[7:0],   hit_word[15:8]};

  always_comb begin
    state_nx = state;
    mreq_int = 1'b0;
    ma_int   = {fetch, 2'b00};
    push     = 1'b0;
    case (state)
      FILL: begin
        mreq_int = (count != CW'(DEPTH));
        if (redirect) begin
          // An unanswered request must be carried to completion and dropped.
          if (mreq_int && !MRDY) state_nx = DISCARD;
        end else begin
          push = mreq_int && MRDY;
        end
      end
      DISCARD: begin
        mreq_int = 1'b1;
        ma_int   = {hold, 2'b00};
        if (MRDY) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  assign CE   = RSTN && hit;
  assign ID   = (RSTN && hit) ? parcel : 16'h0000;
  assign MREQ = RSTN && mreq_int;
  assign MA   = RSTN ? ma_int : 32'h0000_0000;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= FILL;
      count  <= '0;
      base   <= '0;
      fetch  <= '0;
      hold   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        count  <= '0;
        base   <= ia_w;
        fetch  <= ia_w;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (state == FILL && state_nx == DISCARD) hold <= fetch;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          fetch  <= fetch + 30'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          base   <= base + 30'd1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Word storage carries no reset; count/pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= MD;
  end

endmodule

// File: tb/tb_sub86_ifetch.sv
// Randomized scoreboard bench for sub86_ifetch: a core/memory model issues
// IA/MRDY/MD and queues the expected outputs; a monitor pops and compares.
module tb_sub86_ifetch;
  localparam int DEPTH = 4;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] IA   = '0;
  logic [15:0] ID;
  logic        CE;
  logic [31:0] MA;
  logic        MREQ;
  logic        MRDY = 1'b0;
  logic [31:0] MD   = '0;

  always #5 CLK = ~CLK;

  sub86_ifetch #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .IA(IA), .ID(ID), .CE(CE),
    .MA(MA), .MREQ(MREQ), .MRDY(MRDY), .MD(MD)
  );

  typedef struct {
    logic        ce;
    logic [15:0] id;
    logic        mreq;
    logic        chk_ma;
    logic [31:0] ma;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: buffered word addresses, fetch pointer, discard pending.
  logic [29:0] m_base, m_fetch, m_hold;
  logic [29:0] m_buf[$];
  bit          m_disc;
  int          wleft;
  logic [31:0] core_ia;
  int          wait_mode;
  int          jump_div;

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (w == 30'd0) return 32'hE990_C390;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int pick_wait();
    if (wait_mode == 0) return 0;
    if (wait_mode == 1) return 3;
    return $urandom_range(0, 3);
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    do begin
      if ($urandom_range(0, 7) == 0)
        t = 32'hFFFF_FFE0 + 32'($urandom_range(0, 15)) * 2;
      else
        t = 32'($urandom_range(0, 255)) * 2;
    end while (t[31:2] == m_fetch && m_buf.size() == DEPTH);
    return t;
  endfunction

  task automatic model_reset();
    m_base  = '0;
    m_fetch = '0;
    m_hold  = '0;
    m_buf.delete();
    m_disc  = 0;
    wleft   = -1;
    core_ia = '0;
  endtask

  task automatic do_cycle(input bit rst_low);
    exp_t        e;
    logic [29:0] ia_w, off;
    int          cnt;
    bit          hit, pend, mreq, mrdy;
    logic [31:0] ma;
    @(posedge CLK);
    #1;
    if (rst_low) begin
      RSTN = 1'b0;
      IA   = $urandom & 32'hFFFF_FFFE;
      MRDY = 1'($urandom_range(0, 1));
      MD   = $urandom;
      e = '{ce: 1'b0, id: 16'h0, mreq: 1'b0, chk_ma: 1'b1, ma: 32'h0};
      exp_q.push_back(e);
      model_reset();
      return;
    end
    RSTN = 1'b1;
    IA   = core_ia;
    cnt  = m_buf.size();
    ia_w = core_ia[31:2];
    off  = ia_w - m_base;
    hit  = (cnt > 0 && off == 30'd0) || (cnt >= 2 && off == 30'd1);
    if (m_disc) begin
      mreq = 1;
      ma   = {m_hold, 2'b00};
    end else begin
      mreq = (cnt < DEPTH);
      ma   = {m_fetch, 2'b00};
    end
    if (mreq) begin
      if (wleft < 0) wleft = pick_wait();
      mrdy = (wleft == 0);
      if (mrdy) wleft = -1;
      else wleft--;
    end else begin
      mrdy = 1'($urandom_range(0, 1));
    end
    MRDY = mrdy;
    MD   = (mreq && mrdy) ? mem_word(ma[31:2]) : $urandom;
    e.ce     = hit;
    e.id     = hit ? {mem_byte(core_ia), mem_byte(core_ia + 32'd1)} : 16'h0;
    e.mreq   = mreq;
    e.chk_ma = mreq;
    e.ma     = ma;
    exp_q.push_back(e);

    pend = (ia_w == m_fetch) && (off <= 30'(cnt));
    if (!hit && !pend) begin
      if (m_disc) begin
        if (mrdy) m_disc = 0;
      end else if (mreq && !mrdy) begin
        m_disc = 1;
        m_hold = m_fetch;
      end
      m_buf.delete();
      m_base  = ia_w;
      m_fetch = ia_w;
    end else begin
      if (m_disc) begin
        if (mrdy) m_disc = 0;
      end else if (mreq && mrdy) begin
        m_buf.push_back(m_fetch);
        m_fetch = m_fetch + 30'd1;
      end
      if (hit && off == 30'd1) begin
        void'(m_buf.pop_front());
        m_base = m_base + 30'd1;
      end
    end

    if (hit) begin
      if (jump_div > 0 && $urandom_range(1, jump_div) == 1) core_ia = pick_target();
      else core_ia = core_ia + 32'd2;
    end
  endtask

  exp_t me;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      total++;
      if (CE !== me.ce) begin
        bad++;
        $display("FAIL ce: got %b want %b (IA=%h t=%0t)", CE, me.ce, IA, $time);
      end
      total++;
      if (ID !== me.id) begin
        bad++;
        $display("FAIL id: got %h want %h (IA=%h t=%0t)", ID, me.id, IA, $time);
      end
      total++;
      if (MREQ !== me.mreq) begin
        bad++;
        $display("FAIL mreq: got %b want %b (t=%0t)", MREQ, me.mreq, $time);
      end
      if (me.chk_ma) begin
        total++;
        if (MA !== me.ma) begin
          bad++;
          $display("FAIL ma: got %h want %h (t=%0t)", MA, me.ma, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    wait_mode = 0;
    jump_div  = 0;
    repeat (3) do_cycle(1);
    // Zero-wait sequential fetch from 0, including FIFO-full back-pressure.
    repeat (60) do_cycle(0);
    // Three wait cycles per beat, sequential.
    repeat (2) do_cycle(1);
    wait_mode = 1;
    repeat (120) do_cycle(0);
    // Reset while the FIFO is partly filled, then restart at word 0.
    do_cycle(1);
    wait_mode = 0;
    repeat (4) do_cycle(0);
    do_cycle(1);
    repeat (12) do_cycle(0);
    // Random latency with jumps and occasional resets.
    wait_mode = 2;
    jump_div  = 6;
    for (int i = 0; i < 800; i++) do_cycle($urandom_range(0, 199) == 0);
    wait_mode = 0;
    jump_div  = 4;
    repeat (400) do_cycle(0);
    wait_mode = 2;
    jump_div  = 3;
    repeat (400) do_cycle(0);
    wait_mode = 1;
    jump_div  = 2;
    repeat (300) do_cycle(0);
    @(negedge CLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
